// File: rtl/ctrl_decode_reg.sv
// Instruction decode stage with a pipeline register, {N,Z,C,V} status register
// and condition evaluation that gates capture into the register.
module ctrl_decode_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] cond,
  input  logic [1:0] mode,
  input  logic [3:0] opcode,
  input  logic       s_in,
  input  logic       freeze,
  input  logic       flush,
  input  logic       status_we,
  input  logic [3:0] status_in,
  output logic [3:0] exe_cmd,
  output logic       mem_r,
  output logic       mem_w,
  output logic       wb_en,
  output logic       b,
  output logic       s_out,
  output logic       valid_out,
  output logic       illegal,
  output logic [3:0] status,
  output logic       cond_pass
);

  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10,
    MODE_ILL = 2'b11
  } mode_e;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_r;
    logic       mem_w;
    logic       wb_en;
    logic       b;
    logic       s_out;
    logic       valid;
    logic       illegal;
  } ctrl_t;

  ctrl_t      dec;
  ctrl_t      pipe_q;
  logic [3:0] status_q;
  logic       n, z, c, v;

  assign {n, z, c, v} = status_q;

  // Condition is checked against the registered flags only; a same-cycle
  // status write becomes visible one cycle later.
  always_comb begin
    unique case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = !c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = c && !z;
      4'b1001: cond_pass = !c || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every field gets a default first so no path through the case
    // leaves a bit unassigned and infers a latch.
    dec       = '0;
    dec.valid = 1'b1;
    unique case (mode_e'(mode))
      MODE_DP: begin
        dec.wb_en = 1'b1;
        dec.s_out = s_in;
        unique case (opcode)
          4'b0000: dec.exe_cmd = 4'b0110;
          4'b0001: dec.exe_cmd = 4'b1000;
          4'b0010: dec.exe_cmd = 4'b0100;
          4'b0100: dec.exe_cmd = 4'b0010;
          4'b0101: dec.exe_cmd = 4'b0011;
          4'b0110: dec.exe_cmd = 4'b0101;
          4'b1000: begin
            dec.exe_cmd = 4'b0110;
            dec.wb_en   = 1'b0;
            dec.s_out   = 1'b1;
          end
          4'b1010: begin
            dec.exe_cmd = 4'b0100;
            dec.wb_en   = 1'b0;
            dec.s_out   = 1'b1;
          end
          4'b1100: dec.exe_cmd = 4'b0111;
          4'b1101: dec.exe_cmd = 4'b0001;
          4'b1111: dec.exe_cmd = 4'b1001;
          default: begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
          end
        endcase
      end
      MODE_MEM: begin
        dec.exe_cmd = 4'b0010;
        dec.mem_r   = s_in;
        dec.mem_w   = !s_in;
        dec.wb_en   = s_in;
      end
      MODE_BR: dec.b = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else if (flush) begin
      pipe_q <= '0;
    end else if (!freeze) begin
      pipe_q <= (in_valid && cond_pass) ? dec : '0;
    end
  end

  // Status register ignores stall and flush: flags from execute always land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
    end else if (status_we) begin
      status_q <= status_in;
    end
  end

  assign exe_cmd   = pipe_q.exe_cmd;
  assign mem_r     = pipe_q.mem_r;
  assign mem_w     = pipe_q.mem_w;
  assign wb_en     = pipe_q.wb_en;
  assign b         = pipe_q.b;
  assign s_out     = pipe_q.s_out;
  assign valid_out = pipe_q.valid;
  assign illegal   = pipe_q.illegal;
  assign status    = status_q;

endmodule

// File: tb/tb_ctrl_decode_reg.sv
// Scoreboard bench for ctrl_decode_reg: the driver predicts each edge's
// outputs from a table-driven model; a monitor pops and compares after the edge.
module tb_ctrl_decode_reg;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] cond;
  logic [1:0] mode;
  logic [3:0] opcode;
  logic       s_in;
  logic       freeze;
  logic       flush;
  logic       status_we;
  logic [3:0] status_in;
  logic [3:0] exe_cmd;
  logic       mem_r, mem_w, wb_en, b, s_out, valid_out, illegal;
  logic [3:0] status;
  logic       cond_pass;

  int checks   = 0;
  int failures = 0;

  // Expected outputs: {exe_cmd, mem_r, mem_w, wb_en, b, s_out, valid_out, illegal, status}
  logic [14:0] exp_q[$];
  logic [10:0] m_pipe;
  logic [3:0]  m_status;
  logic [3:0]  dp_cmd[int];

  ctrl_decode_reg dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .cond(cond), .mode(mode),
    .opcode(opcode), .s_in(s_in), .freeze(freeze), .flush(flush),
    .status_we(status_we), .status_in(status_in), .exe_cmd(exe_cmd),
    .mem_r(mem_r), .mem_w(mem_w), .wb_en(wb_en), .b(b), .s_out(s_out),
    .valid_out(valid_out), .illegal(illegal), .status(status),
    .cond_pass(cond_pass)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [14:0] outputs_now();
    return {exe_cmd, mem_r, mem_w, wb_en, b, s_out, valid_out, illegal, status};
  endfunction

  // Flag pairs: even cond tests a predicate, the odd partner is its negation.
  function automatic logic model_cond(input logic [3:0] cd, input logic [3:0] st);
    logic nn, zz, cc, vv, base;
    {nn, zz, cc, vv} = st;
    if (cd == 4'd14) return 1'b1;
    if (cd == 4'd15) return 1'b0;
    case (cd >> 1)
      0:       base = zz;
      1:       base = cc;
      2:       base = nn;
      3:       base = vv;
      4:       base = cc & ~zz;
      5:       base = (nn == vv);
      default: base = ~zz & (nn == vv);
    endcase
    return cd[0] ? ~base : base;
  endfunction

  // {exe_cmd, mem_r, mem_w, wb_en, b, s_out, valid, illegal}
  function automatic logic [10:0] model_ctrl(input logic [1:0] md, input logic [3:0] op, input logic s);
    logic is_test;
    if (md == 2'd1) return {4'b0010, s, ~s, s, 1'b0, 1'b0, 1'b1, 1'b0};
    if (md == 2'd2) return {4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    if (md == 2'd0 && dp_cmd.exists(int'(op))) begin
      is_test = (op == 4'b1000) || (op == 4'b1010);
      return {dp_cmd[int'(op)], 1'b0, 1'b0, ~is_test, 1'b0, is_test | s, 1'b1, 1'b0};
    end
    return {4'b0000, 5'b0, 1'b1, 1'b1};
  endfunction

  task automatic step(input logic iv, input logic [3:0] cd, input logic [1:0] md,
                      input logic [3:0] op, input logic s, input logic frz,
                      input logic fl, input logic swe, input logic [3:0] sin);
    logic cp;
    @(negedge clk);
    in_valid = iv; cond = cd; mode = md; opcode = op; s_in = s;
    freeze = frz; flush = fl; status_we = swe; status_in = sin;
    #1;
    cp = model_cond(cd, m_status);
    check("cond_pass", 32'(cond_pass), 32'(cp));
    if (fl)            m_pipe = '0;
    else if (!frz)     m_pipe = (iv && cp) ? model_ctrl(md, op, s) : '0;
    if (swe) m_status = sin;
    exp_q.push_back({m_pipe, m_status});
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    m_pipe = '0;
    m_status = '0;
    #1;
    check("async_reset", 32'(outputs_now()), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [14:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pipe_outputs", 32'(outputs_now()), 32'(e));
      end
    end
  end

  initial begin
    dp_cmd[0]  = 4'b0110; dp_cmd[1]  = 4'b1000; dp_cmd[2]  = 4'b0100;
    dp_cmd[4]  = 4'b0010; dp_cmd[5]  = 4'b0011; dp_cmd[6]  = 4'b0101;
    dp_cmd[8]  = 4'b0110; dp_cmd[10] = 4'b0100; dp_cmd[12] = 4'b0111;
    dp_cmd[13] = 4'b0001; dp_cmd[15] = 4'b1001;
    m_pipe = '0; m_status = '0;
    rst_n = 1'b0; in_valid = 0; cond = 0; mode = 0; opcode = 0; s_in = 0;
    freeze = 0; flush = 0; status_we = 0; status_in = 0;
    #12;
    check("reset_state", 32'(outputs_now()), 32'd0);
    rst_n = 1'b1;

    // ADD, always
    step(1, 4'he, 2'd0, 4'b0100, 1, 0, 0, 0, 4'h0);
    // Z=1, then NE ADD (bubble), then EQ ADD (captured)
    step(0, 4'he, 2'd0, 4'b0000, 0, 0, 0, 1, 4'b0100);
    step(1, 4'h1, 2'd0, 4'b0100, 0, 0, 0, 0, 4'h0);
    step(1, 4'h0, 2'd0, 4'b0100, 0, 0, 0, 0, 4'h0);
    // LDR then STR
    step(1, 4'he, 2'd1, 4'b0000, 1, 0, 0, 0, 4'h0);
    step(1, 4'he, 2'd1, 4'b0000, 0, 0, 0, 0, 4'h0);
    // CMP, three frozen cycles with MOV presented, then freeze+flush
    step(1, 4'he, 2'd0, 4'b1010, 0, 0, 0, 0, 4'h0);
    repeat (3) step(1, 4'he, 2'd0, 4'b1101, 1, 1, 0, 0, 4'h0);
    step(1, 4'he, 2'd0, 4'b1101, 1, 1, 1, 0, 4'h0);
    // Clear flags, then write N while testing MI, then MI again
    step(0, 4'he, 2'd0, 4'b0000, 0, 0, 0, 1, 4'h0);
    step(1, 4'h4, 2'd0, 4'b0100, 0, 0, 0, 1, 4'b1000);
    step(1, 4'h4, 2'd0, 4'b0100, 0, 0, 0, 0, 4'h0);
    // Illegal opcode, illegal mode, branch, never-condition
    step(1, 4'he, 2'd0, 4'b0011, 1, 0, 0, 0, 4'h0);
    step(1, 4'he, 2'd3, 4'b0100, 1, 0, 0, 0, 4'h0);
    step(1, 4'he, 2'd2, 4'b0000, 1, 0, 0, 0, 4'h0);
    step(1, 4'hf, 2'd0, 4'b0100, 1, 0, 0, 0, 4'h0);
    // Reset mid-stall discards the held instruction
    step(1, 4'he, 2'd0, 4'b1100, 1, 0, 0, 1, 4'b0110);
    step(1, 4'he, 2'd0, 4'b0000, 0, 1, 0, 0, 4'h0);
    reset_pulse();
    step(1, 4'he, 2'd0, 4'b0000, 0, 1, 0, 0, 4'h0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom), 4'($urandom), 1'($urandom),
           $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 2) == 0, 4'($urandom));
      if ($urandom_range(0, 99) == 0) reset_pulse();
    end

    @(posedge clk);
    #3;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
